// File: rtl/memorybank_pkg.sv
// Shared types and constants for the memory bank access controller.
// Holds the FSM encoding, bank geometry and the ones'-complement adder.
package memorybank_pkg;

  localparam int MB_WORD_WIDTH = 16;
  localparam int MB_MEM_DEPTH  = 64;
  localparam int MB_LEN_WIDTH  = 6;
  localparam int MB_ADDR_STEP  = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  // 16-bit ones'-complement add; the end-around carry cannot ripple twice.
  function automatic logic [MB_WORD_WIDTH-1:0] ones_add(
    input logic [MB_WORD_WIDTH-1:0] a,
    input logic [MB_WORD_WIDTH-1:0] b
  );
    logic [MB_WORD_WIDTH:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[MB_WORD_WIDTH-1:0] + {{(MB_WORD_WIDTH-1){1'b0}}, sum[MB_WORD_WIDTH]};
  endfunction

endpackage

// File: rtl/memorybank_access_ctrl_if.sv
// Bundle of request, write-data, read-data and bank signals of the access controller.
// slave = the controller itself, master = node logic plus bank model.
interface memorybank_access_ctrl_if
  import memorybank_pkg::*;
#(
  parameter int WORD_WIDTH = MB_WORD_WIDTH,
  parameter int LEN_WIDTH  = MB_LEN_WIDTH
) ();

  // Every stream (req, wdata, rdata) transfers exactly on a cycle where
  // valid && ready are both high at the rising clk edge; once raised, valid
  // and its payload stay stable until that transfer happens.
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [WORD_WIDTH-1:0] req_base;
  logic [LEN_WIDTH-1:0]  req_len;

  logic                  wdata_valid;
  logic                  wdata_ready;
  logic [WORD_WIDTH-1:0] wdata;

  logic                  rdata_valid;
  logic                  rdata_ready;
  logic [WORD_WIDTH-1:0] rdata;

  logic                  done;
  logic                  err;

  logic                  mem_wr_en;
  logic [WORD_WIDTH-1:0] mem_index;
  logic [WORD_WIDTH-1:0] mem_data_in;
  logic [WORD_WIDTH-1:0] mem_data_out;

  logic [WORD_WIDTH-1:0] checksum;
  state_e                dbg_state;

  modport slave (
    input  req_valid, req_write, req_base, req_len,
    input  wdata_valid, wdata,
    input  rdata_ready,
    input  mem_data_out,
    output req_ready, wdata_ready, rdata_valid, rdata,
    output done, err,
    output mem_wr_en, mem_index, mem_data_in,
    output checksum, dbg_state
  );

  modport master (
    output req_valid, req_write, req_base, req_len,
    output wdata_valid, wdata,
    output rdata_ready,
    output mem_data_out,
    input  req_ready, wdata_ready, rdata_valid, rdata,
    input  done, err,
    input  mem_wr_en, mem_index, mem_data_in,
    input  checksum, dbg_state
  );

endinterface

// File: rtl/memorybank_addr_gen.sv
// Burst address generator: latches base/len, walks the word index in steps
// of two bytes, and flags the final word of the burst.
module memorybank_addr_gen
  import memorybank_pkg::*;
#(
  parameter int WORD_WIDTH = MB_WORD_WIDTH,
  parameter int LEN_WIDTH  = MB_LEN_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic [WORD_WIDTH-1:0] base_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  input  logic                  step_i,
  output logic [WORD_WIDTH-1:0] index_o,
  output logic                  last_o
);

  localparam logic [WORD_WIDTH-1:0] STEP = WORD_WIDTH'(MB_ADDR_STEP);
  localparam logic [LEN_WIDTH-1:0]  ONE  = LEN_WIDTH'(1);

  logic [WORD_WIDTH-1:0] index_q, index_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  k_q, k_d;

  assign index_o = index_q;
  assign last_o  = (k_q == (len_q - ONE));

  // The index stops on the final word so it holds the last address in IDLE.
  always_comb begin
    index_d = index_q;
    len_d   = len_q;
    k_d     = k_q;
    if (load_i) begin
      index_d = base_i;
      len_d   = len_i;
      k_d     = '0;
    end else if (step_i) begin
      k_d = k_q + ONE;
      if (!last_o) begin
        index_d = index_q + STEP;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      index_q <= '0;
      len_q   <= '0;
      k_q     <= '0;
    end else begin
      index_q <= index_d;
      len_q   <= len_d;
      k_q     <= k_d;
    end
  end

endmodule

// File: rtl/memorybank_access_ctrl.sv
// Burst initiator for the byte-wide node memory bank (big-endian 16-bit words).
// Build option: define MEMBANK_CHECKSUM_EN for the ones'-complement burst checksum.
module memorybank_access_ctrl
  import memorybank_pkg::*;
#(
  parameter int WORD_WIDTH = MB_WORD_WIDTH,
  parameter int MEM_DEPTH  = MB_MEM_DEPTH,
  parameter int LEN_WIDTH  = MB_LEN_WIDTH
) (
  input logic clk,
  input logic rst,
  memorybank_access_ctrl_if.slave bus
);

  localparam logic [WORD_WIDTH:0] DEPTH_LIM = (WORD_WIDTH+1)'(MEM_DEPTH);

  state_e                state_q, state_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  rdata_valid_q, rdata_valid_d;
  logic [WORD_WIDTH-1:0] rdata_q, rdata_d;

  logic                  ag_load, ag_step, ag_last;
  logic [WORD_WIDTH-1:0] ag_index;

  logic [WORD_WIDTH:0]   len_bytes;
  logic [WORD_WIDTH:0]   req_end;
  logic                  req_bad;
  logic                  wr_fire, rd_load, drain_fire;

  logic                  req_ready_c, wdata_ready_c, mem_wr_en_c;
  logic [WORD_WIDTH-1:0] mem_data_in_c;

  // Range check runs one bit wider than the index so a large base cannot wrap.
  assign len_bytes = {{(WORD_WIDTH-LEN_WIDTH){1'b0}}, bus.req_len, 1'b0};
  assign req_end   = {1'b0, bus.req_base} + len_bytes;
  assign req_bad   = bus.req_base[0] || (req_end > DEPTH_LIM);

  memorybank_addr_gen #(
    .WORD_WIDTH (WORD_WIDTH),
    .LEN_WIDTH  (LEN_WIDTH)
  ) u_addr_gen (
    .clk     (clk),
    .rst     (rst),
    .load_i  (ag_load),
    .base_i  (bus.req_base),
    .len_i   (bus.req_len),
    .step_i  (ag_step),
    .index_o (ag_index),
    .last_o  (ag_last)
  );

  always_comb begin
    state_d       = state_q;
    done_d        = 1'b0;
    err_d         = 1'b0;
    rdata_valid_d = rdata_valid_q;
    rdata_d       = rdata_q;
    ag_load       = 1'b0;
    ag_step       = 1'b0;
    wr_fire       = 1'b0;
    rd_load       = 1'b0;
    drain_fire    = 1'b0;
    req_ready_c   = 1'b0;
    wdata_ready_c = 1'b0;
    mem_wr_en_c   = 1'b0;
    mem_data_in_c = '0;

    case (state_q)
      ST_IDLE: begin
        // No new request in the done cycle or while reset is held.
        req_ready_c = !done_q && !rst;
        if (bus.req_valid && req_ready_c) begin
          if (req_bad) begin
            err_d = 1'b1;
          end else if (bus.req_len == '0) begin
            done_d = 1'b1;
          end else begin
            ag_load = 1'b1;
            state_d = bus.req_write ? ST_WRITE : ST_READ;
          end
        end
      end

      ST_WRITE: begin
        wdata_ready_c = 1'b1;
        mem_wr_en_c   = bus.wdata_valid;
        mem_data_in_c = bus.wdata;
        if (bus.wdata_valid) begin
          wr_fire = 1'b1;
          ag_step = 1'b1;
          if (ag_last) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end

      ST_READ: begin
        if (!rdata_valid_q || bus.rdata_ready) begin
          rd_load       = 1'b1;
          rdata_d       = bus.mem_data_out;
          rdata_valid_d = 1'b1;
          ag_step       = 1'b1;
          if (ag_last) begin
            state_d = ST_DRAIN;
          end
        end
      end

      ST_DRAIN: begin
        if (rdata_valid_q && bus.rdata_ready) begin
          drain_fire    = 1'b1;
          rdata_valid_d = 1'b0;
          state_d       = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      rdata_valid_q <= 1'b0;
      rdata_q       <= '0;
    end else begin
      state_q       <= state_d;
      done_q        <= done_d;
      err_q         <= err_d;
      rdata_valid_q <= rdata_valid_d;
      rdata_q       <= rdata_d;
    end
  end

  // The read burst reports completion in the cycle its last word is consumed.
  assign bus.done        = done_q || (drain_fire && !rst);
  assign bus.err         = err_q;
  assign bus.req_ready   = req_ready_c;
  assign bus.wdata_ready = wdata_ready_c;
  assign bus.rdata_valid = rdata_valid_q;
  assign bus.rdata       = rdata_q;
  assign bus.mem_wr_en   = mem_wr_en_c;
  assign bus.mem_index   = ag_index;
  assign bus.mem_data_in = mem_data_in_c;
  assign bus.dbg_state   = state_q;

`ifdef MEMBANK_CHECKSUM_EN
  logic [WORD_WIDTH-1:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (ag_load) begin
      csum_d = '0;
    end else if (wr_fire) begin
      csum_d = ones_add(csum_q, bus.wdata);
    end else if (rd_load) begin
      csum_d = ones_add(csum_q, bus.mem_data_out);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign bus.checksum = csum_q;
`else
  assign bus.checksum = '0;
`endif

endmodule

// File: tb/tb_memorybank_access_ctrl.sv
// Directed bench for memorybank_access_ctrl with a byte-wide bank model.
// Expected words, bytes and checksums are hand-computed constants.
module tb_memorybank_access_ctrl;
  import memorybank_pkg::*;

`ifdef MEMBANK_CHECKSUM_EN
  localparam bit CS_EN = 1'b1;
`else
  localparam bit CS_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  logic bank_clr;

  memorybank_access_ctrl_if bus ();

  memorybank_access_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bank model ----------------
  logic [7:0] bank [MB_MEM_DEPTH];
  logic [5:0] bidx;
  logic [5:0] bidx1;
  assign bidx  = bus.mem_index[5:0];
  assign bidx1 = bidx + 6'd1;
  assign bus.mem_data_out = {bank[bidx], bank[bidx1]};

  always @(posedge clk) begin
    if (bank_clr) begin
      for (int i = 0; i < MB_MEM_DEPTH; i++) bank[i] <= 8'h00;
    end else if (bus.mem_wr_en) begin
      bank[bidx]  <= bus.mem_data_in[15:8];
      bank[bidx1] <= bus.mem_data_in[7:0];
    end
  end

  // ---------------- event monitor ----------------
  int done_cnt = 0;
  int err_cnt  = 0;
  int wr_cnt   = 0;
  always @(negedge clk) begin
    if (bus.done)      done_cnt++;
    if (bus.err)       err_cnt++;
    if (bus.mem_wr_en) wr_cnt++;
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_q[$];
  logic [15:0] wbuf [8];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req_ready"},   32'(bus.req_ready),   0);
    check({tag, "_wdata_ready"}, 32'(bus.wdata_ready), 0);
    check({tag, "_rdata_valid"}, 32'(bus.rdata_valid), 0);
    check({tag, "_rdata"},       32'(bus.rdata),       0);
    check({tag, "_done"},        32'(bus.done),        0);
    check({tag, "_err"},         32'(bus.err),         0);
    check({tag, "_mem_wr_en"},   32'(bus.mem_wr_en),   0);
    check({tag, "_mem_index"},   32'(bus.mem_index),   0);
    check({tag, "_mem_data_in"}, 32'(bus.mem_data_in), 0);
    check({tag, "_checksum"},    32'(bus.checksum),    0);
    check({tag, "_state"},       32'(bus.dbg_state),   32'(ST_IDLE));
  endtask

  // ---------------- driver tasks (called at posedge+1) ----------------
  task automatic send_req(input logic wr, input logic [15:0] base, input logic [5:0] len);
    int n = 0;
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_base  = base;
    bus.req_len   = len;
    #1;
    while (!bus.req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("req_ready_wait", 32'(bus.req_ready), 1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic do_write(input logic [15:0] base, input int len, input bit gap,
                          input logic [15:0] cs_exp);
    int d0 = done_cnt;
    send_req(1'b1, base, 6'(len));
    for (int i = 0; i < len; i++) begin
      if (gap && i == 1) begin
        bus.wdata_valid = 1'b0;
        #1;
        check("wr_gap_wr_en", 32'(bus.mem_wr_en), 0);
        @(posedge clk); #1;
      end
      bus.wdata_valid = 1'b1;
      bus.wdata       = wbuf[i];
      #1;
      check("wr_ready",   32'(bus.wdata_ready), 1);
      check("wr_en",      32'(bus.mem_wr_en),   1);
      check("wr_index",   32'(bus.mem_index),   32'(base) + 32'(2*i));
      check("wr_data_in", 32'(bus.mem_data_in), 32'(wbuf[i]));
      @(posedge clk); #1;
    end
    bus.wdata_valid = 1'b0;
    #1;
    check("wr_done",      32'(bus.done),      1);
    check("wr_done_rdy",  32'(bus.req_ready), 0);
    check("wr_done_st",   32'(bus.dbg_state), 32'(ST_IDLE));
    check("wr_checksum",  32'(bus.checksum),  32'(cs_exp));
    @(posedge clk); #1;
    check("wr_post_done", 32'(bus.done),      0);
    check("wr_post_rdy",  32'(bus.req_ready), 1);
    check("wr_done_cnt",  done_cnt - d0,      1);
  endtask

  task automatic do_read(input logic [15:0] base, input int len, input int stall,
                         input logic [15:0] cs_exp);
    int got     = 0;
    int budget  = 0;
    int stalled = 0;
    send_req(1'b0, base, 6'(len));
    check("rd_first_invalid", 32'(bus.rdata_valid), 0);
    while (got < len && budget < 100) begin
      bus.rdata_ready = !(bus.rdata_valid && stalled < stall);
      #1;
      if (bus.rdata_valid && !bus.rdata_ready) begin
        stalled++;
        check("rd_hold_data",  32'(bus.rdata),     32'(exp_q[0]));
        check("rd_hold_index", 32'(bus.mem_index), 32'(base) + 32'd2);
      end else if (bus.rdata_valid) begin
        check("rd_data", 32'(bus.rdata), 32'(exp_q.pop_front()));
        got++;
        if (got == len) begin
          check("rd_done",     32'(bus.done),     1);
          check("rd_checksum", 32'(bus.checksum), 32'(cs_exp));
        end
      end
      @(posedge clk); #1;
      budget++;
    end
    check("rd_words", got, len);
    bus.rdata_ready = 1'b0;
    #1;
    check("rd_post_valid", 32'(bus.rdata_valid), 0);
    check("rd_post_done",  32'(bus.done),        0);
    check("rd_post_rdy",   32'(bus.req_ready),   1);
    check("rd_post_state", 32'(bus.dbg_state),   32'(ST_IDLE));
  endtask

  task automatic reject(input logic [15:0] base, input logic [5:0] len);
    int w0 = wr_cnt;
    send_req(1'b1, base, len);
    #1;
    check("rej_err",   32'(bus.err),       1);
    check("rej_done",  32'(bus.done),      0);
    check("rej_state", 32'(bus.dbg_state), 32'(ST_IDLE));
    @(posedge clk); #1;
    check("rej_err_clr", 32'(bus.err),       0);
    check("rej_rdy",     32'(bus.req_ready), 1);
    check("rej_no_wr",   wr_cnt - w0,        0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int w0;
    int d0;
    logic [7:0] t1_bytes [6];
    t1_bytes = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6};

    rst = 1'b1;
    bank_clr = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_base = '0;
    bus.req_len = '0;
    bus.wdata_valid = 1'b0;
    bus.wdata = '0;
    bus.rdata_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    bank_clr = 1'b0;
    #1;
    check("reset_rel_rdy", 32'(bus.req_ready), 1);
    @(posedge clk); #1;

    // Write then read back three words at 0x0010.
    wbuf[0] = 16'hA1B2; wbuf[1] = 16'hC3D4; wbuf[2] = 16'hE5F6;
    do_write(16'h0010, 3, 1'b0, CS_EN ? 16'h4B7E : 16'h0000);
    for (int i = 0; i < 6; i++) check("t1_bank", 32'(bank[16+i]), 32'(t1_bytes[i]));
    exp_q.push_back(16'hA1B2); exp_q.push_back(16'hC3D4); exp_q.push_back(16'hE5F6);
    do_read(16'h0010, 3, 0, CS_EN ? 16'h4B7E : 16'h0000);

    // Write with a valid gap, then read with consumer backpressure.
    wbuf[0] = 16'h1111; wbuf[1] = 16'h2222; wbuf[2] = 16'h3333; wbuf[3] = 16'h4444;
    do_write(16'h0000, 4, 1'b1, CS_EN ? 16'hAAAA : 16'h0000);
    exp_q.push_back(16'h1111); exp_q.push_back(16'h2222);
    exp_q.push_back(16'h3333); exp_q.push_back(16'h4444);
    do_read(16'h0000, 4, 3, CS_EN ? 16'hAAAA : 16'h0000);

    // Rejections and the exact upper boundary.
    reject(16'h003F, 6'd1);
    reject(16'h003E, 6'd2);
    wbuf[0] = 16'hBEEF;
    do_write(16'h003E, 1, 1'b0, CS_EN ? 16'hBEEF : 16'h0000);
    check("bnd_bank62", 32'(bank[62]), 32'h0000_00BE);
    check("bnd_bank63", 32'(bank[63]), 32'h0000_00EF);

    // Zero length.
    w0 = wr_cnt;
    d0 = done_cnt;
    send_req(1'b1, 16'h0010, 6'd0);
    #1;
    check("zl_done", 32'(bus.done),      1);
    check("zl_rdy",  32'(bus.req_ready), 0);
    @(posedge clk); #1;
    check("zl_done_clr", 32'(bus.done),      0);
    check("zl_rdy_back", 32'(bus.req_ready), 1);
    check("zl_no_wr",    wr_cnt - w0,        0);
    check("zl_done_cnt", done_cnt - d0,      1);

    // Reset after two of four write words.
    wbuf[0] = 16'h5A5A; wbuf[1] = 16'h6B6B; wbuf[2] = 16'h7C7C; wbuf[3] = 16'h8D8D;
    d0 = done_cnt;
    send_req(1'b1, 16'h0020, 6'd4);
    for (int i = 0; i < 2; i++) begin
      bus.wdata_valid = 1'b1;
      bus.wdata = wbuf[i];
      @(posedge clk); #1;
    end
    bus.wdata_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    check_all_zero("midrst");
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("midrst_no_done", done_cnt - d0, 0);
    check("midrst_b20", 32'(bank[32]), 32'h5A);
    check("midrst_b21", 32'(bank[33]), 32'h5A);
    check("midrst_b22", 32'(bank[34]), 32'h6B);
    check("midrst_b23", 32'(bank[35]), 32'h6B);
    check("midrst_b24", 32'(bank[36]), 32'h00);
    check("midrst_b27", 32'(bank[39]), 32'h00);

    // Checksum end-around carry and plain sum.
    wbuf[0] = 16'hFFFF; wbuf[1] = 16'h0001;
    do_write(16'h0030, 2, 1'b0, CS_EN ? 16'h0001 : 16'h0000);
    wbuf[0] = 16'h1234; wbuf[1] = 16'h4321;
    do_write(16'h0034, 2, 1'b0, CS_EN ? 16'h5555 : 16'h0000);
    check("final_err_cnt", err_cnt, 2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/memorybank_access_ctrl.md
Name: memorybank_access_ctrl

Overview:
- Initiator for the node memory bank (byte-wide, 64-deep array accessed as big-endian 16-bit words at index/index+1).
- Accepts one burst request (read or write, base byte address, word count) and sequences word accesses at base, base+2, base+4, …
- Write data enters on a valid/ready stream; read data leaves on a valid/ready stream.
- Sits between the node packet/RL logic and the memory bank; it is the only driver of the bank's wr_en/index/data_in.

Parameters:
- WORD_WIDTH, 16, data and index width.
- MEM_DEPTH, 64, bank depth in bytes.
- LEN_WIDTH, 6, width of the word-count field (max 32 words).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  1  burst request valid.
- req_ready  out  1  high only in IDLE.
- req_write  in  1  1 = write burst, 0 = read burst.
- req_base  in  WORD_WIDTH  starting byte index.
- req_len  in  LEN_WIDTH  number of words.
- wdata_valid  in  1  write word valid.
- wdata_ready  out  1  write word accepted.
- wdata  in  WORD_WIDTH  write word.
- rdata_valid  out  1  read word valid.
- rdata_ready  in  1  consumer ready.
- rdata  out  WORD_WIDTH  read word.
- done  out  1  one-cycle pulse when a burst completes.
- err  out  1  one-cycle pulse when a request is rejected.
- mem_wr_en  out  1  to bank wr_en.
- mem_index  out  WORD_WIDTH  to bank index.
- mem_data_in  out  WORD_WIDTH  to bank data_in.
- mem_data_out  in  WORD_WIDTH  from bank data_out (combinational read).
- checksum  out  WORD_WIDTH  burst checksum (see Optional Feature).

Behaviour:
- Reset state: the FSM goes to IDLE. All of the following are 0: req_ready, wdata_ready, rdata_valid, rdata, done, err, mem_wr_en, mem_index, mem_data_in, checksum. The internal counters are also cleared.
- rst mid-burst: the burst is abandoned with no done pulse. Bytes already written stay in the bank.
- FSM states: IDLE, WRITE, READ, DRAIN.
- IDLE, request handshake: a request is taken on req_valid && req_ready. The module latches base, len and dir.
- IDLE, rejection: the request is rejected (err pulses next cycle, state stays IDLE, no memory access) when either condition holds:
  - req_base is odd;
  - req_base + 2*req_len > MEM_DEPTH. This check uses a WORD_WIDTH+1-bit sum, with no wrap.
- IDLE, zero length: req_len == 0 gives a done pulse next cycle and no access.
- IDLE, accepted request: otherwise the FSM goes to WRITE or READ.
- Address counter: mem_index = base + 2*k, where k is the number of words transferred so far. k increments by 1 per transferred word.
- WRITE:
  - wdata_ready = 1.
  - mem_wr_en = wdata_valid (combinational).
  - mem_data_in = wdata, mem_index = current address.
  - The bank captures the word on the same clk edge as the handshake.
  - On the len-th handshake: go to IDLE and pulse done next cycle.
  - Throughput: 1 word/cycle; wdata_valid gaps stall the burst.
- READ:
  - mem_wr_en = 0.
  - rdata is a register loaded with mem_data_out at mem_index when !rdata_valid || rdata_ready.
  - On each load: rdata_valid = 1 and k advances.
  - First rdata_valid comes 1 cycle after entering READ.
  - rdata_ready = 0 holds rdata/rdata_valid stable and holds mem_index.
  - After the len-th load: go to DRAIN.
- DRAIN: when the final rdata is consumed (rdata_valid && rdata_ready), clear rdata_valid, go to IDLE, and pulse done in that same cycle.
- Outside the active state: mem_wr_en is never high outside WRITE. mem_index holds its last value in IDLE.
- Simultaneous done and new request: req_ready rises the cycle after done. A new request cannot be accepted in the done cycle.

Optional Feature:
- Macro: MEMBANK_CHECKSUM_EN.
- Defined: checksum accumulates the 16-bit ones'-complement sum (end-around carry) of every word transferred in the burst, written or read.
  - It is cleared when a request is accepted.
  - It is final and stable from the done pulse until the next accepted request.
- Undefined: checksum is tied to 0 and no accumulator logic is built.

Decomposition:
- Shared package memorybank_pkg holds:
  - the FSM state encoding (IDLE/WRITE/READ/DRAIN);
  - WORD_WIDTH, MEM_DEPTH and the address step of 2;
  - the ones'-complement add function used by the checksum.
- One sub-module, memorybank_addr_gen: latches base/len, produces mem_index, advances on step, and flags last word.

Test Plan:
- Write then read: write burst base=0x0010, len=3, words 0xA1B2,0xC3D4,0xE5F6 → bank bytes [16..21] = A1 B2 C3 D4 E5 F6, done after 3rd handshake. Read burst with the same base and len returns the same 3 words in order, then done.
- Read backpressure: read base=0, len=4, rdata_ready low 3 cycles after first valid → rdata holds word 0, mem_index holds 0x0002, no words lost or duplicated.
- Rejects: req_base=0x003F len=1 → err pulse, no mem_wr_en. req_base=0x003E len=2 → err. req_base=0x003E len=1 → accepted, bytes 62/63 written.
- Zero length: req_len=0 → done next cycle, mem_wr_en never asserts, req_ready returns high.
- Reset mid-burst: rst asserted after 2 of 4 write words → all outputs 0 next cycle, FSM IDLE, no done, first 2 words remain in bank.
- Checksum (MEMBANK_CHECKSUM_EN): write 0xFFFF,0x0001 → checksum 0x0001. Write 0x1234,0x4321 → 0x5555.
